// File: rtl/core_ctrl.sv
// core_ctrl: sequences one convolution run across len_kij kernel positions.
// Per kij: kernel rows are fetched from xmem into L0, loaded into the PEs,
// activations are fetched and executed, and psum rows are drained from the
// OFIFO into pmem.
//
// state  | meaning
// IDLE   | waiting for start
// WLD    | read col kernel rows from xmem (L0 write trails by one cycle)
// WDRN   | last delayed L0 write of the kernel rows
// PELOAD | shift col rows from L0 into the PEs
// GAP    | idle spacing before activation fetch
// ALD    | read len_nij activation vectors from xmem
// ADRN   | last delayed L0 write of the activations
// EXEC   | stream len_nij vectors from L0 through the array
// OFRD   | drain len_nij psum rows from OFIFO into pmem
// NEXT   | advance kij or finish
// DONE   | one-cycle done pulse
module core_ctrl #(
    parameter int col     = 8,
    parameter int len_nij = 36,
    parameter int len_kij = 9,
    parameter int gap     = 10,
    parameter int w_base  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        ofifo_valid,
    output logic [33:0] inst,
    output logic        busy,
    output logic        done,
    output logic [3:0]  kij
);

    typedef enum logic [3:0] {
        IDLE, WLD, WDRN, PELOAD, GAP, ALD, ADRN, EXEC, OFRD, NEXT, DONE
    } state_t;

    localparam logic [33:0] INST_IDLE = 34'h1800C0000;
    localparam logic [10:0] COL_W     = 11'(col);
    localparam logic [10:0] LEN_W     = 11'(len_nij);
    localparam logic [10:0] GAP_W     = 11'(gap);
    localparam logic [10:0] WB_W      = 11'(w_base);
    localparam logic [3:0]  KIJ_LAST  = 4'(len_kij - 1);

    state_t      state;
    logic [33:0] inst_q;
    logic [10:0] tmr;
    logic [10:0] rd_cnt;
    logic [10:0] pmem_base;
    logic [10:0] w_next;
    logic        ofifo_rd;

    assign pmem_base = 11'(kij) * LEN_W;
    assign w_next    = WB_W + 11'(kij + 4'd1) * COL_W;

    // The OFIFO read strobe must follow ofifo_valid in the same cycle, so it
    // is the one inst bit decoded from registered state rather than stored.
    assign ofifo_rd = (state == OFRD) && ofifo_valid && (rd_cnt < LEN_W);
    assign inst     = inst_q | {27'd0, ofifo_rd, 6'd0};
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    // Sequencer: state, stage timer, read counter and the next inst word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            inst_q <= INST_IDLE;
            tmr    <= 11'd0;
            rd_cnt <= 11'd0;
            kij    <= 4'd0;
        end else begin
            inst_q    <= INST_IDLE;
            // every xmem read lands in L0 one cycle later
            inst_q[2] <= ~inst_q[19];
            if (ofifo_rd) begin
                inst_q[32]    <= 1'b0;
                inst_q[31]    <= 1'b0;
                inst_q[30:20] <= pmem_base + rd_cnt;
                rd_cnt        <= rd_cnt + 11'd1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= WLD;
                        kij          <= 4'd0;
                        tmr          <= COL_W - 11'd1;
                        inst_q[19]   <= 1'b0;
                        inst_q[17:7] <= WB_W;
                    end
                end
                WLD: begin
                    if (tmr == 11'd0) begin
                        state <= WDRN;
                    end else begin
                        tmr          <= tmr - 11'd1;
                        inst_q[19]   <= 1'b0;
                        inst_q[17:7] <= inst_q[17:7] + 11'd1;
                    end
                end
                WDRN: begin
                    state     <= PELOAD;
                    tmr       <= COL_W - 11'd1;
                    inst_q[3] <= 1'b1;
                    inst_q[0] <= 1'b1;
                end
                PELOAD: begin
                    if (tmr == 11'd0) begin
                        state <= GAP;
                        tmr   <= GAP_W - 11'd1;
                    end else begin
                        tmr       <= tmr - 11'd1;
                        inst_q[3] <= 1'b1;
                        inst_q[0] <= 1'b1;
                    end
                end
                GAP: begin
                    if (tmr == 11'd0) begin
                        state        <= ALD;
                        tmr          <= LEN_W - 11'd1;
                        inst_q[19]   <= 1'b0;
                        inst_q[17:7] <= 11'd0;
                    end else begin
                        tmr <= tmr - 11'd1;
                    end
                end
                ALD: begin
                    if (tmr == 11'd0) begin
                        state <= ADRN;
                    end else begin
                        tmr          <= tmr - 11'd1;
                        inst_q[19]   <= 1'b0;
                        inst_q[17:7] <= inst_q[17:7] + 11'd1;
                    end
                end
                ADRN: begin
                    state     <= EXEC;
                    tmr       <= LEN_W - 11'd1;
                    inst_q[3] <= 1'b1;
                    inst_q[1] <= 1'b1;
                end
                EXEC: begin
                    if (tmr == 11'd0) begin
                        state  <= OFRD;
                        rd_cnt <= 11'd0;
                    end else begin
                        tmr       <= tmr - 11'd1;
                        inst_q[3] <= 1'b1;
                        inst_q[1] <= 1'b1;
                    end
                end
                OFRD: begin
                    // leave once the final pmem write is on the bus
                    if (!inst_q[32] && (rd_cnt == LEN_W)) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (kij == KIJ_LAST) begin
                        state <= DONE;
                    end else begin
                        state        <= WLD;
                        kij          <= kij + 4'd1;
                        tmr          <= COL_W - 11'd1;
                        inst_q[19]   <= 1'b0;
                        inst_q[17:7] <= w_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// tb_core_ctrl: directed scenario tests for core_ctrl at default parameters.
module tb_core_ctrl;

    localparam logic [33:0] INST_IDLE  = 34'h1800C0000;
    localparam int          RUN_CYCLES = 9 * 138 + 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        valid_fixed = 1'b1;
    logic        tog = 1'b0;
    logic        toggle_en = 1'b0;
    logic        ofifo_valid;
    logic [33:0] inst;
    logic        busy;
    logic        done;
    logic [3:0]  kij;

    int checks = 0;
    int errors = 0;

    logic clr = 1'b0;
    int   pm_cnt, pm_next, pm_addr_err, pm_last;
    int   rd_cnt, rd_bad, busy_cyc, done_cnt, fixed_bad;
    int   wk [0:15];

    assign ofifo_valid = toggle_en ? tog : valid_fixed;

    core_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done),
        .kij         (kij)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // alternating ofifo_valid source, changes just after each rising edge
    always @(posedge clk) begin
        #1 tog = ~tog;
    end

    // recorder: pmem write sequence, strobe legality and run statistics
    always @(negedge clk) begin
        if (clr) begin
            pm_cnt = 0; pm_next = 0; pm_addr_err = 0; pm_last = -1;
            rd_cnt = 0; rd_bad = 0; busy_cyc = 0; done_cnt = 0; fixed_bad = 0;
            for (int k = 0; k < 16; k++) wk[k] = 0;
        end else if (!reset) begin
            if (busy) busy_cyc++;
            if (done) done_cnt++;
            if (inst[33] || inst[5] || inst[4]) fixed_bad++;
            if (inst[6]) begin
                rd_cnt++;
                if (!ofifo_valid) rd_bad++;
            end
            if (!inst[32]) begin
                if (inst[31] !== 1'b0 || int'(inst[30:20]) != pm_next) pm_addr_err++;
                pm_last = int'(inst[30:20]);
                pm_next++;
                pm_cnt++;
                wk[kij]++;
            end
        end
    end

    task automatic clear_mon();
        clr = 1'b1;
        @(negedge clk);
        #1 clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        checks++; if (inst !== INST_IDLE) begin errors++; $display("FAIL reset_inst got %h want %h", inst, INST_IDLE); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (kij !== 4'd0) begin errors++; $display("FAIL reset_kij got %0d want 0", kij); end
        #1 reset = 1'b0;
    endtask

    task automatic test_full_run();
        bit seen;
        valid_fixed = 1'b1;
        clear_mon();
        pulse_start();
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL full_done_timeout got %b want 1", seen); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_busy_in_done got %b want 1", busy); end
        checks++; if (kij !== 4'd8) begin errors++; $display("FAIL full_kij_last got %0d want 8", kij); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL full_done_after got %b want 0", done); end
        repeat (20) @(negedge clk);
        #1;
        checks++; if (kij !== 4'd8) begin errors++; $display("FAIL full_kij_hold got %0d want 8", kij); end
        checks++; if (pm_cnt != 324) begin errors++; $display("FAIL full_pm_count got %0d want 324", pm_cnt); end
        checks++; if (pm_addr_err != 0) begin errors++; $display("FAIL full_pm_order got %0d want 0", pm_addr_err); end
        checks++; if (pm_last != 323) begin errors++; $display("FAIL full_pm_last got %0d want 323", pm_last); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count got %0d want 1", done_cnt); end
        checks++; if (busy_cyc != RUN_CYCLES) begin errors++; $display("FAIL full_busy_cycles got %0d want %0d", busy_cyc, RUN_CYCLES); end
        checks++; if (fixed_bad != 0) begin errors++; $display("FAIL full_fixed_bits got %0d want 0", fixed_bad); end
        checks++; if (rd_cnt != 324) begin errors++; $display("FAIL full_rd_count got %0d want 324", rd_cnt); end
    endtask

    task automatic test_wld_kij3();
        bit seen;
        bit found;
        logic [10:0] want_a;
        logic        want_l0;
        valid_fixed = 1'b1;
        clear_mon();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (kij == 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL wld3_reach got %b want 1", found); end
        for (int t = 0; t < 10; t++) begin
            want_a  = 11'(1048 + t);
            want_l0 = (t >= 1 && t <= 8);
            if (t < 8) begin
                checks++; if (inst[19] !== 1'b0 || inst[18] !== 1'b1) begin errors++; $display("FAIL wld3_cen_wen t=%0d got %b%b want 01", t, inst[19], inst[18]); end
                checks++; if (inst[17:7] !== want_a) begin errors++; $display("FAIL wld3_addr t=%0d got %0d want %0d", t, inst[17:7], want_a); end
            end else begin
                checks++; if (inst[19] !== 1'b1) begin errors++; $display("FAIL wld3_cen_end t=%0d got %b want 1", t, inst[19]); end
            end
            checks++; if (inst[2] !== want_l0) begin errors++; $display("FAIL wld3_l0wr t=%0d got %b want %b", t, inst[2], want_l0); end
            @(negedge clk);
        end
        wait_done(seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL wld3_done_timeout got %b want 1", seen); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_toggle();
        bit seen;
        bit kbad;
        toggle_en = 1'b1;
        clear_mon();
        pulse_start();
        wait_done(seen);
        repeat (3) @(negedge clk);
        #1;
        toggle_en = 1'b0;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tog_done_timeout got %b want 1", seen); end
        checks++; if (rd_bad != 0) begin errors++; $display("FAIL tog_rd_invalid got %0d want 0", rd_bad); end
        checks++; if (pm_addr_err != 0) begin errors++; $display("FAIL tog_pm_order got %0d want 0", pm_addr_err); end
        checks++; if (pm_cnt != 324) begin errors++; $display("FAIL tog_pm_count got %0d want 324", pm_cnt); end
        kbad = 1'b0;
        for (int k = 0; k < 9; k++) begin
            checks++; if (wk[k] != 36) begin errors++; kbad = 1'b1; $display("FAIL tog_kij_writes kij=%0d got %0d want 36", k, wk[k]); end
        end
        checks++; if (rd_cnt != 324) begin errors++; $display("FAIL tog_rd_count got %0d want 324", rd_cnt); end
    endtask

    task automatic test_start_in_exec();
        bit seen;
        bit found;
        valid_fixed = 1'b1;
        clear_mon();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (kij == 4'd1 && inst[1] == 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL exec_reach got %b want 1", found); end
        pulse_start();
        wait_done(seen);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL exec_done_timeout got %b want 1", seen); end
        checks++; if (busy_cyc != RUN_CYCLES) begin errors++; $display("FAIL exec_busy_cycles got %0d want %0d", busy_cyc, RUN_CYCLES); end
        checks++; if (pm_cnt != 324) begin errors++; $display("FAIL exec_pm_count got %0d want 324", pm_cnt); end
        checks++; if (pm_addr_err != 0) begin errors++; $display("FAIL exec_pm_order got %0d want 0", pm_addr_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL exec_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_mid_reset();
        bit seen;
        bit found;
        valid_fixed = 1'b1;
        clear_mon();
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (kij == 4'd5 && inst[19] == 1'b0 && inst[17:7] == 11'd5) begin
                found = 1'b1;
                break;
            end
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL mrst_reach got %b want 1", found); end
        #1 reset = 1'b1;
        #1;
        checks++; if (inst !== INST_IDLE) begin errors++; $display("FAIL mrst_inst got %h want %h", inst, INST_IDLE); end
        checks++; if (kij !== 4'd0) begin errors++; $display("FAIL mrst_kij got %0d want 0", kij); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy got %b want 0", busy); end
        clear_mon();
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mrst_restart_busy got %b want 1", busy); end
        checks++; if (inst[19] !== 1'b0 || inst[17:7] !== 11'd1024) begin errors++; $display("FAIL mrst_restart_addr got %b/%0d want 0/1024", inst[19], inst[17:7]); end
        wait_done(seen);
        repeat (3) @(negedge clk);
        #1;
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL mrst_done_timeout got %b want 1", seen); end
        checks++; if (busy_cyc != RUN_CYCLES) begin errors++; $display("FAIL mrst_busy_cycles got %0d want %0d", busy_cyc, RUN_CYCLES); end
        checks++; if (pm_cnt != 324 || pm_addr_err != 0) begin errors++; $display("FAIL mrst_pm got %0d/%0d want 324/0", pm_cnt, pm_addr_err); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL mrst_done_count got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_wld_kij3();
        test_toggle();
        test_start_in_exec();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
